hazard_sequencer: RTL and testbench

Pipeline sequencing controller for the five-stage 64-bit CPU. It detects load-use data hazards between ID/EX and IF/ID, and stalls the PC and IF/ID registers while injecting an ID/EX bubble. It squashes IF/ID, ID/EX and EX/MEM when a branch resolves taken in EX/MEM, and holds the pipeline quiet for a programmable number of cycles after reset. Outputs drive the `wPC`/write-enable and flush/bubble inputs of the PC and the pipeline registers; saturating counters expose stall and flush statistics.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/sat_counter.sv | 19 +
 rtl/hazard_sequencer.sv | 136 +++++++++++++
 tb/tb_hazard_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        LU_STALL = 2'd2,
        BR_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Load-use stall / taken-branch flush controller with post-reset quiet period.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int START_DELAY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IFID_rn,
    input  logic [REG_W-1:0] IFID_rm,
    input  logic             IFID_rm_used,
    input  logic             IDEX_readMem,
    input  logic [REG_W-1:0] IDEX_rd,
    input  logic             EXMEM_Branch,
    input  logic             EXMEM_Z,
    output logic             wPC,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_bubble,
    output logic             EXMEM_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state
);

    localparam logic [1:0] S_INIT     = INIT;
    localparam logic [1:0] S_RUN      = RUN;
    localparam logic [1:0] S_LU_STALL = LU_STALL;
    localparam logic [1:0] S_BR_FLUSH = BR_FLUSH;

    // The delay counter runs one past START_DELAY so RUN begins START_DELAY+1
    // cycles after the first edge that sees rst_n high.
    localparam int                DLY_W    = $clog2(START_DELAY + 2);
    localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(START_DELAY + 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [DLY_W-1:0] dly_q;
    logic             lu_hazard;
    logic             taken;
    logic             stall_inc;
    logic             flush_inc;

    assign lu_hazard = IDEX_readMem && (IDEX_rd != XZR) &&
                       ((IDEX_rd == IFID_rn) || (IFID_rm_used && (IDEX_rd == IFID_rm)));
    assign taken     = EXMEM_Branch && EXMEM_Z;

    always_comb begin
        state_d     = state_q;
        wPC         = 1'b1;
        IFID_write  = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_bubble = 1'b0;
        EXMEM_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        state       = state_q;

        if (!rst_n) begin
            state       = S_INIT;
            state_d     = S_INIT;
            wPC         = 1'b0;
            IFID_write  = 1'b0;
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
            EXMEM_flush = 1'b1;
        end else begin
            case (state_q)
                S_INIT: begin
                    wPC         = 1'b0;
                    IFID_write  = 1'b0;
                    IFID_flush  = 1'b1;
                    IDEX_bubble = 1'b1;
                    EXMEM_flush = 1'b1;
                    if (dly_q == DLY_LAST) state_d = S_RUN;
                end
                S_RUN, S_LU_STALL: begin
                    // Flush outranks a coincident load-use hazard; LU_STALL masks the hazard.
                    if (taken) begin
                        IFID_flush  = 1'b1;
                        IDEX_bubble = 1'b1;
                        EXMEM_flush = 1'b1;
                        flush_inc   = 1'b1;
                        state_d     = S_BR_FLUSH;
                    end else if ((state_q == S_RUN) && lu_hazard) begin
                        wPC         = 1'b0;
                        IFID_write  = 1'b0;
                        IDEX_bubble = 1'b1;
                        stall_inc   = 1'b1;
                        state_d     = S_LU_STALL;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_BR_FLUSH: begin
                    if (lu_hazard) begin
                        wPC         = 1'b0;
                        IFID_write  = 1'b0;
                        IDEX_bubble = 1'b1;
                        stall_inc   = 1'b1;
                        state_d     = S_LU_STALL;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_INIT) && (dly_q != DLY_LAST)) dly_q <= dly_q + DLY_W'(1);
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: table of per-cycle vectors plus reset corner cases.
module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] IFID_rn, IFID_rm, IDEX_rd;
    logic       IFID_rm_used, IDEX_readMem, EXMEM_Branch, EXMEM_Z;
    logic       wPC, IFID_write, IFID_flush, IDEX_bubble, EXMEM_flush;
    logic [15:0] stall_count, flush_count;
    logic [1:0] state;
    logic       s_wPC, s_IFID_write, s_IFID_flush, s_IDEX_bubble, s_EXMEM_flush;
    logic [1:0] s_stall_count, s_flush_count;
    logic [1:0] s_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .IFID_rn(IFID_rn), .IFID_rm(IFID_rm), .IFID_rm_used(IFID_rm_used),
        .IDEX_readMem(IDEX_readMem), .IDEX_rd(IDEX_rd),
        .EXMEM_Branch(EXMEM_Branch), .EXMEM_Z(EXMEM_Z),
        .wPC(wPC), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
        .IDEX_bubble(IDEX_bubble), .EXMEM_flush(EXMEM_flush),
        .stall_count(stall_count), .flush_count(flush_count), .state(state)
    );

    hazard_sequencer #(.CNT_W(2), .START_DELAY(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .IFID_rn(IFID_rn), .IFID_rm(IFID_rm), .IFID_rm_used(IFID_rm_used),
        .IDEX_readMem(IDEX_readMem), .IDEX_rd(IDEX_rd),
        .EXMEM_Branch(EXMEM_Branch), .EXMEM_Z(EXMEM_Z),
        .wPC(s_wPC), .IFID_write(s_IFID_write), .IFID_flush(s_IFID_flush),
        .IDEX_bubble(s_IDEX_bubble), .EXMEM_flush(s_EXMEM_flush),
        .stall_count(s_stall_count), .flush_count(s_flush_count), .state(s_state)
    );

    // outs = {wPC, IFID_write, IFID_flush, IDEX_bubble, EXMEM_flush}
    localparam logic [4:0] O_N = 5'b11000;
    localparam logic [4:0] O_I = 5'b00111;
    localparam logic [4:0] O_S = 5'b00010;
    localparam logic [4:0] O_F = 5'b11111;

    typedef struct {
        logic       ld;
        logic [4:0] rd, rn, rm;
        logic       used, br, z;
        logic [4:0] outs;
        logic [1:0] st;
        int         sc, fc;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic ld, input logic [4:0] rd, input logic [4:0] rn,
                                input logic [4:0] rm, input logic used, input logic br,
                                input logic z, input logic [4:0] outs, input logic [1:0] st,
                                input int sc, input int fc);
        vec_t v;
        v.ld = ld; v.rd = rd; v.rn = rn; v.rm = rm; v.used = used; v.br = br; v.z = z;
        v.outs = outs; v.st = st; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        IDEX_readMem = v.ld; IDEX_rd = v.rd; IFID_rn = v.rn; IFID_rm = v.rm;
        IFID_rm_used = v.used; EXMEM_Branch = v.br; EXMEM_Z = v.z;
    endtask

    function automatic logic [4:0] outs_now();
        return {wPC, IFID_write, IFID_flush, IDEX_bubble, EXMEM_flush};
    endfunction

    initial begin
        //            ld rd  rn  rm  used br z  outs st  sc fc
        vecs[0]  = mk(0, 0,  0,  0,  0,  1, 1, O_I, 0, 0, 0);  // taken ignored in INIT
        vecs[1]  = mk(1, 3,  3,  0,  0,  0, 0, O_I, 0, 0, 0);  // hazard ignored in INIT
        vecs[2]  = mk(0, 0,  0,  0,  0,  0, 0, O_I, 0, 0, 0);
        vecs[3]  = mk(0, 0,  0,  0,  0,  0, 0, O_I, 0, 0, 0);
        vecs[4]  = mk(0, 0,  0,  0,  0,  0, 0, O_N, 1, 0, 0);  // first RUN cycle
        vecs[5]  = mk(1, 3,  3,  0,  0,  0, 0, O_S, 1, 0, 0);  // load-use on rn
        vecs[6]  = mk(0, 0,  0,  0,  0,  0, 0, O_N, 2, 1, 0);
        vecs[7]  = mk(1, 3,  3,  0,  0,  0, 0, O_S, 1, 1, 0);
        vecs[8]  = mk(1, 3,  3,  0,  0,  0, 0, O_N, 2, 2, 0);  // suppressed in LU_STALL
        vecs[9]  = mk(1, 31, 31, 0,  0,  0, 0, O_N, 1, 2, 0);  // XZR never hazards
        vecs[10] = mk(1, 4,  0,  4,  0,  0, 0, O_N, 1, 2, 0);  // rm unused
        vecs[11] = mk(1, 4,  0,  4,  1,  0, 0, O_S, 1, 2, 0);  // load-use on rm
        vecs[12] = mk(0, 0,  0,  0,  0,  0, 0, O_N, 2, 3, 0);
        vecs[13] = mk(0, 0,  0,  0,  0,  1, 1, O_F, 1, 3, 0);  // taken in RUN
        vecs[14] = mk(0, 0,  0,  0,  0,  1, 1, O_N, 3, 3, 1);  // taken ignored in BR_FLUSH
        vecs[15] = mk(1, 5,  5,  0,  0,  1, 1, O_F, 1, 3, 1);  // taken + hazard: flush wins
        vecs[16] = mk(0, 0,  0,  0,  0,  0, 0, O_N, 3, 3, 2);
        vecs[17] = mk(1, 6,  6,  0,  0,  0, 0, O_S, 1, 3, 2);
        vecs[18] = mk(0, 0,  0,  0,  0,  1, 1, O_F, 2, 4, 2);  // taken in LU_STALL
        vecs[19] = mk(1, 7,  0,  7,  1,  1, 1, O_S, 3, 4, 3);  // hazard in BR_FLUSH
        vecs[20] = mk(0, 0,  0,  0,  0,  0, 0, O_N, 2, 5, 3);
        vecs[21] = mk(0, 0,  0,  0,  0,  1, 0, O_N, 1, 5, 3);  // branch not taken
        vecs[22] = mk(0, 0,  0,  0,  0,  0, 0, O_N, 1, 5, 3);

        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, O_N, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        check("reset_outs", outs_now(), O_I);
        check("reset_state", state, 0);
        check("reset_stall_count", stall_count, 0);
        check("reset_flush_count", flush_count, 0);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            if (i == 0) rst_n = 1'b1;
            #2;
            check($sformatf("v%0d_outs", i), outs_now(), vecs[i].outs);
            check($sformatf("v%0d_state", i), state, vecs[i].st);
            check($sformatf("v%0d_stall_count", i), stall_count, vecs[i].sc);
            check($sformatf("v%0d_flush_count", i), flush_count, vecs[i].fc);
        end

        // Five stalls and three flushes on a 2-bit counter
        check("sat_stall_count", s_stall_count, 3);
        check("sat_flush_count", s_flush_count, 3);

        // Reset asserted while in LU_STALL
        @(negedge clk);
        drive(mk(1, 3, 3, 0, 0, 0, 0, O_N, 0, 0, 0));
        #2;
        check("pre_rst_stall_wpc", wPC, 0);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, O_N, 0, 0, 0));
        #2;
        check("pre_rst_state", state, 2);
        rst_n = 1'b0;
        @(negedge clk); #2;
        check("midrst_state", state, 0);
        check("midrst_wpc", wPC, 0);
        check("midrst_stall_count", stall_count, 0);
        check("midrst_flush_count", flush_count, 0);
        check("midrst_sat_stall_count", s_stall_count, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #2;
            check($sformatf("reinit_%0d_state", k), state, 0);
        end
        @(negedge clk); #2;
        check("rerun_state", state, 1);
        check("rerun_wpc", wPC, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
